// File: rtl/sync_pkg.sv
// Shared limits and sizing helpers for the multi-channel synchronizer.
package sync_pkg;

   localparam int MAX_STAGES = 4;
   localparam int MAX_FILTER = 255;

   // Counter width able to hold 0..n (the filter never counts past n-1).
   function automatic int filt_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sync_chan.sv
// One synchronizer channel: flop chain, stability filter, and registered
// rise/fall pulses aligned with the first cycle sync_out shows a new level.
module sync_chan
   import sync_pkg::*;
#(
   parameter int   STAGES        = 2,
   parameter int   FILTER_CYCLES = 1,
   parameter logic RESET_VAL     = 1'b0
) (
   input  logic clk,
   input  logic n_rst,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   localparam int                CNT_W    = filt_cnt_w(FILTER_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   logic [STAGES-1:0] stage_q, stage_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              out_q, out_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic              raw;
   logic              commit;

   // Pure shift wiring: only the last stage feeds any decision logic.
   always_comb begin
      stage_d = {stage_q[STAGES-2:0], async_in};
   end

   assign raw = stage_q[STAGES-1];

   // A raw level that is not provably different from sync_out (including X)
   // clears the count, so unknowns can never be committed to the output.
   always_comb begin
      cnt_d  = cnt_q;
      out_d  = out_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      commit = 1'b0;
      if (raw != out_q) begin
         if (cnt_q == CNT_LAST) begin
            commit = 1'b1;
            out_d  = raw;
            cnt_d  = '0;
            rise_d = raw;
            fall_d = ~raw;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stage_q <= {STAGES{RESET_VAL}};
         cnt_q   <= '0;
         out_q   <= RESET_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign sync_out = out_q;
   assign rise     = rise_q;
   assign fall     = fall_q;

endmodule

// File: rtl/sync_multi_filt.sv
// Multi-channel synchronizer with glitch filter and edge pulses for
// asynchronous level inputs arriving at the chip boundary.
module sync_multi_filt
   import sync_pkg::*;
#(
   parameter int                NUM_CH        = 4,
   parameter int                STAGES        = 2,
   parameter int                FILTER_CYCLES = 1,
   parameter logic [NUM_CH-1:0] RESET_VAL     = '0
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [NUM_CH-1:0] async_in,
   output logic [NUM_CH-1:0] sync_out,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] fall
);

   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("sync_multi_filt: NUM_CH=%0d must be at least 1", NUM_CH);
   end

   if (STAGES < 2 || STAGES > MAX_STAGES) begin : g_bad_stages
      $error("sync_multi_filt: STAGES=%0d outside 2..%0d", STAGES, MAX_STAGES);
   end

   if (FILTER_CYCLES < 1 || FILTER_CYCLES > MAX_FILTER) begin : g_bad_filter
      $error("sync_multi_filt: FILTER_CYCLES=%0d outside 1..%0d",
             FILTER_CYCLES, MAX_FILTER);
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      sync_chan #(
         .STAGES        (STAGES),
         .FILTER_CYCLES (FILTER_CYCLES),
         .RESET_VAL     (RESET_VAL[gi])
      ) u_chan (
         .clk      (clk),
         .n_rst    (n_rst),
         .async_in (async_in[gi]),
         .sync_out (sync_out[gi]),
         .rise     (rise[gi]),
         .fall     (fall[gi])
      );
   end

endmodule

// File: tb/tb_sync_multi_filt.sv
// Directed bench for sync_multi_filt: three configurations sharing clock and
// reset, a vector table for cycle-exact behaviour, and corner-case sequences.
`timescale 1ns/1ps
module tb_sync_multi_filt;
   import sync_pkg::*;

   logic       clk;
   logic       n_rst;
   logic [3:0] ain_a, ain_b, ain_c;
   logic [3:0] out_a, rise_a, fall_a;
   logic [3:0] out_b, rise_b, fall_b;
   logic [3:0] out_c, rise_c, fall_c;

   int errors = 0;
   int checks = 0;

   // A: defaults with mixed reset levels; B: 3-cycle filter; C: 3 stages, 4-cycle filter
   sync_multi_filt #(.NUM_CH(4), .STAGES(2), .FILTER_CYCLES(1), .RESET_VAL(4'b1010)) u_a (
      .clk(clk), .n_rst(n_rst), .async_in(ain_a),
      .sync_out(out_a), .rise(rise_a), .fall(fall_a));

   sync_multi_filt #(.NUM_CH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VAL(4'b0000)) u_b (
      .clk(clk), .n_rst(n_rst), .async_in(ain_b),
      .sync_out(out_b), .rise(rise_b), .fall(fall_b));

   sync_multi_filt #(.NUM_CH(4), .STAGES(3), .FILTER_CYCLES(4), .RESET_VAL(4'b0000)) u_c (
      .clk(clk), .n_rst(n_rst), .async_in(ain_c),
      .sync_out(out_c), .rise(rise_c), .fall(fall_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100us;
      $display("FAIL watchdog: time limit reached got running required finished");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] ain;
      logic [3:0] out;
      logic [3:0] rise;
      logic [3:0] fall;
   } vec_t;

   localparam int NVEC = 26;
   vec_t tbl [NVEC];

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      logic [3:0] o, r, f;

      // A, one-cycle filter: sync_out follows async_in two edges after capture
      tbl[0]  = '{2'd0, 4'b1010, 4'b1010, 4'b0000, 4'b0000};
      tbl[1]  = '{2'd0, 4'b1011, 4'b1010, 4'b0000, 4'b0000};
      tbl[2]  = '{2'd0, 4'b1011, 4'b1010, 4'b0000, 4'b0000};
      tbl[3]  = '{2'd0, 4'b0011, 4'b1011, 4'b0001, 4'b0000};
      tbl[4]  = '{2'd0, 4'b0110, 4'b1011, 4'b0000, 4'b0000};
      tbl[5]  = '{2'd0, 4'b1001, 4'b0011, 4'b0000, 4'b1000};
      tbl[6]  = '{2'd0, 4'b1001, 4'b0110, 4'b0100, 4'b0001};
      tbl[7]  = '{2'd0, 4'b1001, 4'b1001, 4'b1001, 4'b0110};
      tbl[8]  = '{2'd0, 4'b1000, 4'b1001, 4'b0000, 4'b0000};
      tbl[9]  = '{2'd0, 4'b1001, 4'b1001, 4'b0000, 4'b0000};
      tbl[10] = '{2'd0, 4'b1001, 4'b1000, 4'b0000, 4'b0001};
      tbl[11] = '{2'd0, 4'b1001, 4'b1001, 4'b0001, 4'b0000};
      // B, three-cycle filter on ch1: 2-cycle glitch rejected, 3-cycle hold accepted
      tbl[12] = '{2'd1, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      tbl[13] = '{2'd1, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      tbl[14] = '{2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[15] = '{2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[16] = '{2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[17] = '{2'd1, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      tbl[18] = '{2'd1, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      tbl[19] = '{2'd1, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      tbl[20] = '{2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      tbl[21] = '{2'd1, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
      tbl[22] = '{2'd1, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
      tbl[23] = '{2'd1, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
      tbl[24] = '{2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
      tbl[25] = '{2'd1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

      // Reset asserted mid-cycle before the first clock edge
      n_rst = 1'b1;
      ain_a = 4'b1010;
      ain_b = 4'b0000;
      ain_c = 4'b0000;
      #1 n_rst = 1'b0;
      #1;
      chk("rst_out_a", out_a, 4'b1010);
      chk("rst_pulse_a", rise_a | fall_a, 4'b0000);
      chk("rst_out_b", out_b, 4'b0000);
      chk("rst_out_c", out_c, 4'b0000);
      repeat (2) @(negedge clk);
      chk("rst_hold_out_a", out_a, 4'b1010);
      chk("rst_hold_pulse_a", rise_a | fall_a, 4'b0000);

      n_rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("release_out_a", out_a, 4'b1010);
         chk("release_pulse_a", rise_a | fall_a, 4'b0000);
      end

      for (int i = 0; i < NVEC; i++) begin
         case (tbl[i].sel)
            2'd0:    ain_a = tbl[i].ain;
            2'd1:    ain_b = tbl[i].ain;
            default: ain_c = tbl[i].ain;
         endcase
         @(negedge clk);
         case (tbl[i].sel)
            2'd0:    begin o = out_a; r = rise_a; f = fall_a; end
            2'd1:    begin o = out_b; r = rise_b; f = fall_b; end
            default: begin o = out_c; r = rise_c; f = fall_c; end
         endcase
         $display("vec %0d sel=%0d ain=%b out=%b rise=%b fall=%b",
                  i, tbl[i].sel, tbl[i].ain, o, r, f);
         chk($sformatf("vec%0d_out", i), o, tbl[i].out);
         chk($sformatf("vec%0d_rise", i), r, tbl[i].rise);
         chk($sformatf("vec%0d_fall", i), f, tbl[i].fall);
      end

      // Asynchronous reset in the middle of a cycle with A away from its reset level
      @(posedge clk);
      #3 n_rst = 1'b0;
      #1;
      chk("midrst_out_a", out_a, 4'b1010);
      chk("midrst_pulse_a", rise_a | fall_a, 4'b0000);
      ain_a = 4'b1010;
      repeat (2) @(negedge clk);
      chk("midrst_hold_a", out_a, 4'b1010);
      n_rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrst_release_pulse_a", rise_a | fall_a, 4'b0000);
      end

      // C: reset pulse while the filter count is at 2 restarts chain and count
      @(negedge clk);
      ain_c = 4'b0001;
      repeat (5) @(posedge clk);
      #2 n_rst = 1'b0;
      #1;
      chk("filtrst_out_c", out_c, 4'b0000);
      #1 n_rst = 1'b1;
      for (int m = 1; m <= 8; m++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("filtrst_m%0d_out_c", m), out_c, (m >= 7) ? 4'b0001 : 4'b0000);
         chk($sformatf("filtrst_m%0d_rise_c", m), rise_c, (m == 7) ? 4'b0001 : 4'b0000);
      end

      // Setup/hold violation: 100 ps pulse straddling a rising edge on ch2 of A and B
      @(posedge clk);
      #9.905;
      ain_a[2] = 1'b1;
      ain_b[2] = 1'b1;
      #0.1;
      ain_a[2] = 1'b0;
      ain_b[2] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("viol_known_a", {3'b000, $isunknown(out_a)}, 4'b0000);
      chk("viol_known_b", {3'b000, $isunknown(out_b)}, 4'b0000);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("viol_excl_a", rise_a & fall_a, 4'b0000);
         chk("viol_reject_b", out_b, 4'b0000);
      end
      chk("viol_settle_a", out_a, 4'b1010);

      // Unknown inputs on every channel of every instance
      ain_a = 'x;
      ain_b = 'x;
      ain_c = 'x;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         chk("xs_known_a", {3'b000, $isunknown(out_a)}, 4'b0000);
         chk("xs_known_b", {3'b000, $isunknown(out_b)}, 4'b0000);
         chk("xs_known_c", {3'b000, $isunknown(out_c)}, 4'b0000);
         chk("xs_excl_a", rise_a & fall_a, 4'b0000);
         chk("xs_excl_b", rise_b & fall_b, 4'b0000);
         chk("xs_excl_c", rise_c & fall_c, 4'b0000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
